// File: rtl/router_pkg.sv
// Shared router types: arbiter state encoding, default widths and index-width helper.
// The packet-buffer arbiter honours ARB_FIXED_PRIORITY_EN (fixed priority instead of round-robin).
package router_pkg;

  localparam int NUM_REQ_DEF    = 2;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int LEN_WIDTH_DEF  = 5;
  // The beat counter spans the whole address space so base+beat wraps naturally.
  localparam int BEAT_WIDTH_DEF = ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BURST   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_pick.sv
// Combinational requester picker: round-robin from ptr, or lowest-index-wins
// when ARB_FIXED_PRIORITY_EN is defined (the ptr port then disappears).
module rr_pick
  import router_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) winner = IDX_W'(k);
    end
    found = |req;
  end
`else
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    sum    = '0;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    // Walk ptr, ptr+1, ... wrapping at NUM_REQ; first requester seen wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port packet-buffer arbiter: grants one burst requester at a time and sequences
// the buffer address/enable. ARB_FIXED_PRIORITY_EN selects fixed priority over round-robin.
module mem_access_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            burst_last,
  output logic                            busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [IDX_W-1:0]       pick;
  logic                   found;
  logic                   last_beat;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req_valid),
`ifndef ARB_FIXED_PRIORITY_EN
    .ptr    (ptr_q),
`endif
    .winner (pick),
    .found  (found)
  );

  assign last_beat = (beat_q == ADDR_WIDTH'(len_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      len_q    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   state_d = BURST;
      BURST:   if (last_beat) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only when leaving IDLE; later req_* changes are ignored.
  always_comb begin
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    len_d    = len_q;
`ifndef ARB_FIXED_PRIORITY_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          winner_d = pick;
          we_d     = req_we[pick];
          addr_d   = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          len_d    = req_len[pick*LEN_WIDTH +: LEN_WIDTH];
          beat_d   = '0;
        end
      end
      BURST: beat_d = last_beat ? '0 : beat_q + 1'b1;
      RELEASE: begin
`ifndef ARB_FIXED_PRIORITY_EN
        ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt        = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    burst_last = 1'b0;
    busy       = (state_q != IDLE);
    if (state_q == GRANT || state_q == BURST) gnt[winner_q] = 1'b1;
    if (state_q == BURST) begin
      mem_en     = 1'b1;
      mem_we     = we_q;
      mem_addr   = addr_q + beat_q;
      burst_last = last_beat;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter; the arbitration-order section follows ARB_FIXED_PRIORITY_EN.
module tb_mem_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [19:0] req_addr;
  logic [9:0]  req_len;
  logic [1:0]  gnt;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic        burst_last;
  logic        busy;

  int vectors;
  int miscompares;

  mem_access_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .gnt        (gnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .burst_last (burst_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int who, input logic we, input logic [9:0] addr, input logic [4:0] len);
    req_we[who]          = we;
    req_addr[who*10+:10] = addr;
    req_len[who*5+:5]    = len;
    req_valid[who]       = 1'b1;
  endtask

  // Starts in IDLE with requester 'who' about to win; ends after the following IDLE cycle.
  task automatic do_burst(input int who, input logic [9:0] base, input int len,
                          input logic we, input bit drop);
    logic [9:0] a;
    tick();
    chk("grant_gnt", 32'(gnt), 32'(1 << who));
    chk("grant_en", 32'(mem_en), 32'd0);
    chk("grant_busy", 32'(busy), 32'd1);
    if (drop) begin
      req_valid[who]       = 1'b0;
      req_addr[who*10+:10] = ~base;
      req_len[who*5+:5]    = 5'd0;
      req_we[who]          = ~we;
    end
    for (int b = 0; b <= len; b++) begin
      tick();
      a = base + 10'(b);
      chk("beat_en", 32'(mem_en), 32'd1);
      chk("beat_we", 32'(mem_we), 32'(we));
      chk("beat_addr", 32'(mem_addr), 32'(a));
      chk("beat_last", 32'(burst_last), (b == len) ? 32'd1 : 32'd0);
      chk("beat_gnt", 32'(gnt), 32'(1 << who));
    end
    tick();
    chk("rel_gnt", 32'(gnt), 32'd0);
    chk("rel_en", 32'(mem_en), 32'd0);
    chk("rel_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_last"}, 32'(burst_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_we      = '0;
    req_addr    = '0;
    req_len     = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Single read, fields scrambled after grant must not matter.
    set_req(0, 1'b0, 10'h3F0, 5'd3);
    do_burst(0, 10'h3F0, 3, 1'b0, 1'b1);

    // Address wrap past the top of the buffer.
    set_req(0, 1'b0, 10'h3FE, 5'd3);
    do_burst(0, 10'h3FE, 3, 1'b0, 1'b1);

    // Single-beat write from requester 1.
    set_req(1, 1'b1, 10'h155, 5'd0);
    do_burst(1, 10'h155, 0, 1'b1, 1'b1);

`ifndef ARB_FIXED_PRIORITY_EN
    // ptr = 0: both request, 0 then 1.
    set_req(0, 1'b0, 10'h010, 5'd1);
    set_req(1, 1'b1, 10'h020, 5'd2);
    do_burst(0, 10'h010, 1, 1'b0, 1'b1);
    do_burst(1, 10'h020, 2, 1'b1, 1'b1);
    // Requester 0 alone moves ptr to 1; then both request, 1 wins first.
    set_req(0, 1'b0, 10'h030, 5'd0);
    do_burst(0, 10'h030, 0, 1'b0, 1'b1);
    set_req(0, 1'b1, 10'h040, 5'd1);
    set_req(1, 1'b0, 10'h050, 5'd1);
    do_burst(1, 10'h050, 1, 1'b0, 1'b1);
    do_burst(0, 10'h040, 1, 1'b1, 1'b1);
    // Both held continuously: service alternates.
    set_req(0, 1'b0, 10'h060, 5'd0);
    set_req(1, 1'b0, 10'h070, 5'd0);
    do_burst(1, 10'h070, 0, 1'b0, 1'b0);
    do_burst(0, 10'h060, 0, 1'b0, 1'b1);
    do_burst(1, 10'h070, 0, 1'b0, 1'b1);
`else
    // Requester 0 held: requester 1 starves until 0 lets go.
    set_req(0, 1'b0, 10'h060, 5'd0);
    set_req(1, 1'b0, 10'h070, 5'd0);
    do_burst(0, 10'h060, 0, 1'b0, 1'b0);
    do_burst(0, 10'h060, 0, 1'b0, 1'b0);
    do_burst(0, 10'h060, 0, 1'b0, 1'b1);
    do_burst(1, 10'h070, 0, 1'b0, 1'b1);
`endif

    // Reset at beat 2 of an 19-beat write burst.
    set_req(0, 1'b1, 10'h100, 5'd18);
    tick();
    chk("rst_grant", 32'(gnt), 32'd1);
    tick();
    tick();
    tick();
    chk("rst_beat2_addr", 32'(mem_addr), 32'h102);
    chk("rst_beat2_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("after_mid_reset");

    // Fresh bursts start at beat 0; pointer is back at 0 so requester 0 goes first.
    set_req(0, 1'b0, 10'h200, 5'd1);
    set_req(1, 1'b1, 10'h2F0, 5'd2);
    do_burst(0, 10'h200, 1, 1'b0, 1'b1);
    do_burst(1, 10'h2F0, 2, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
